hash_target_checker: RTL and testbench

- Consumes the eight 32-bit SHA-256 result words produced by the hasher for one candidate nonce.
- Decodes the Bitcoin compact "bits" field into a 256-bit target.
- Reports per nonce whether hash <= target.
- Sits downstream of the hasher; its result drives the nonce-found decision to the control logic.

---
 rtl/hash_target_checker.sv | 224 ++++++++++++++++++++++
 tb/tb_hash_target_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hash_target_checker.sv
// hash_target_checker
//   Compares a streamed 256-bit SHA-256 result, 8 x 32-bit words with the most
//   significant word first, against a target. The target is decoded from the
//   Bitcoin compact "bits" field. The verdict is hash <= target.
//
//   Ports:
//     clk, rst          rising-edge clock, asynchronous active-high reset
//     bits, bits_load   compact target; the strobe captures it and re-decodes
//     hash_valid/ready  word handshake (hash_word, hash_last, nonce)
//     result_valid      one-cycle verdict pulse, with meets_target/found_nonce
//     frame_error       one-cycle pulse when hash_last lands at a wrong index
//     target_invalid    level; the decoded target is unusable (sign or E>32)
//
//   Optional: `define HASH_CHECK_LZ_COUNT_EN adds leading_zeros[8:0]. It is the
//   leading-zero count of the hash, is updated with result_valid, and is 256
//   for an all-zero hash.
module hash_target_checker #(
  parameter int NONCE_W   = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        bits,
  input  logic               bits_load,
  input  logic               hash_valid,
  output logic               hash_ready,
  input  logic [31:0]        hash_word,
  input  logic               hash_last,
  input  logic [NONCE_W-1:0] nonce,
  output logic               result_valid,
  output logic               meets_target,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               frame_error,
`ifdef HASH_CHECK_LZ_COUNT_EN
  output logic [8:0]         leading_zeros,
`endif
  output logic               target_invalid
);
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_READY, S_RESULT} state_e;
  typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_e;

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  cmp_e                 status_q, status_d;
  logic [31:0]          bits_q, bits_d;
  logic [255:0]         target_q, target_d;
  logic                 tinv_q, tinv_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic                 rv_q, rv_d;
  logic                 meets_q, meets_d;
  logic [NONCE_W-1:0]   found_q, found_d;
  logic                 ferr_q, ferr_d;

  logic [7:0]           exp_w;
  logic [255:0]         mant, dec_target;
  logic                 dec_inv;
  logic [31:0]          tword;
  cmp_e                 cmp_in, cmp_out;
  logic                 xfer;

`ifdef HASH_CHECK_LZ_COUNT_EN
  logic [8:0] lz_acc_q, lz_acc_d, lz_q, lz_d, lz_in, lz_next;
  logic       lz_zero_q, lz_zero_d, zero_in, zero_next;

  function automatic logic [5:0] clz32(input logic [31:0] w);
    logic [5:0] n;
    logic       done;
    n    = 6'd0;
    done = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) done = 1'b1;
      else if (!done) n = n + 6'd1;
    end
    return n;
  endfunction
`endif

  always_comb begin
    // Compact decode, evaluated from the captured bits during DECODE.
    exp_w   = bits_q[31:24];
    mant    = {233'd0, bits_q[22:0]};
    dec_inv = bits_q[23] | (exp_w > 8'd32);
    if (dec_inv)            dec_target = '0;
    else if (exp_w >= 8'd3) dec_target = mant << {exp_w - 8'd3, 3'b000};
    else                    dec_target = mant >> {8'd3 - exp_w, 3'b000};

    // Target word for the current index; word 0 is bits 255:224.
    tword = target_q[{3'd7 - idx_q, 5'd0} +: 32];

    // The status restarts at word 0 and is frozen once a word differs.
    cmp_in  = (idx_q == 3'd0) ? CMP_EQ : status_q;
    cmp_out = cmp_in;
    if (cmp_in == CMP_EQ) begin
      if (hash_word < tword)      cmp_out = CMP_LT;
      else if (hash_word > tword) cmp_out = CMP_GT;
    end

    // A load wins over a word offered in the same cycle.
    xfer = (state_q == S_READY) && hash_valid && !bits_load;

    state_d  = state_q;
    idx_d    = idx_q;
    status_d = status_q;
    bits_d   = bits_q;
    target_d = target_q;
    tinv_d   = tinv_q;
    nonce_d  = nonce_q;
    rv_d     = 1'b0;
    meets_d  = meets_q;
    found_d  = found_q;
    ferr_d   = 1'b0;

`ifdef HASH_CHECK_LZ_COUNT_EN
    lz_in     = (idx_q == 3'd0) ? 9'd0 : lz_acc_q;
    zero_in   = (idx_q == 3'd0) ? 1'b1 : lz_zero_q;
    lz_next   = lz_in;
    zero_next = zero_in;
    if (zero_in) begin
      lz_next   = lz_in + 9'(clz32(hash_word));
      zero_next = (hash_word == 32'd0);
    end
    lz_acc_d  = lz_acc_q;
    lz_zero_d = lz_zero_q;
    lz_d      = lz_q;
`endif

    case (state_q)
      S_DECODE: begin
        target_d = dec_target;
        tinv_d   = dec_inv;
        idx_d    = 3'd0;
        state_d  = S_READY;
      end
      S_READY: begin
        if (xfer) begin
          if (hash_last && (idx_q != LAST_IDX)) begin
            // Short frame: drop it and resynchronise at word 0.
            ferr_d = 1'b1;
            idx_d  = 3'd0;
          end else begin
            status_d = cmp_out;
            if (idx_q == 3'd0) nonce_d = nonce;
            idx_d = idx_q + 3'd1;
`ifdef HASH_CHECK_LZ_COUNT_EN
            lz_acc_d  = lz_next;
            lz_zero_d = zero_next;
`endif
            if (idx_q == LAST_IDX) begin
              rv_d    = 1'b1;
              meets_d = (cmp_out != CMP_GT) && !tinv_q;
              found_d = nonce_q;
              idx_d   = 3'd0;
              state_d = S_RESULT;
`ifdef HASH_CHECK_LZ_COUNT_EN
              lz_d = lz_next;
`endif
            end
          end
        end
      end
      S_RESULT: begin
        idx_d   = 3'd0;
        state_d = S_READY;
      end
      default: ;
    endcase

    if (bits_load) begin
      bits_d  = bits;
      idx_d   = 3'd0;
      state_d = S_DECODE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      status_q  <= CMP_EQ;
      bits_q    <= '0;
      target_q  <= '0;
      tinv_q    <= 1'b0;
      nonce_q   <= '0;
      rv_q      <= 1'b0;
      meets_q   <= 1'b0;
      found_q   <= '0;
      ferr_q    <= 1'b0;
`ifdef HASH_CHECK_LZ_COUNT_EN
      lz_acc_q  <= '0;
      lz_zero_q <= 1'b1;
      lz_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      status_q  <= status_d;
      bits_q    <= bits_d;
      target_q  <= target_d;
      tinv_q    <= tinv_d;
      nonce_q   <= nonce_d;
      rv_q      <= rv_d;
      meets_q   <= meets_d;
      found_q   <= found_d;
      ferr_q    <= ferr_d;
`ifdef HASH_CHECK_LZ_COUNT_EN
      lz_acc_q  <= lz_acc_d;
      lz_zero_q <= lz_zero_d;
      lz_q      <= lz_d;
`endif
    end
  end

  assign hash_ready     = (state_q == S_READY);
  assign result_valid   = rv_q;
  assign meets_target   = meets_q;
  assign found_nonce    = found_q;
  assign frame_error    = ferr_q;
  assign target_invalid = tinv_q;
`ifdef HASH_CHECK_LZ_COUNT_EN
  assign leading_zeros  = lz_q;
`endif
endmodule

// File: tb/tb_hash_target_checker.sv
// Directed bench for hash_target_checker. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_hash_target_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bits;
  logic        bits_load;
  logic        hash_valid;
  logic        hash_ready;
  logic [31:0] hash_word;
  logic        hash_last;
  logic [31:0] nonce;
  logic        result_valid;
  logic        meets_target;
  logic [31:0] found_nonce;
  logic        frame_error;
  logic        target_invalid;
`ifdef HASH_CHECK_LZ_COUNT_EN
  logic [8:0]  leading_zeros;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] hw [8];

  hash_target_checker #(.NONCE_W(32), .NUM_WORDS(8)) dut (
    .clk(clk), .rst(rst), .bits(bits), .bits_load(bits_load),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_word(hash_word),
    .hash_last(hash_last), .nonce(nonce), .result_valid(result_valid),
    .meets_target(meets_target), .found_nonce(found_nonce),
    .frame_error(frame_error),
`ifdef HASH_CHECK_LZ_COUNT_EN
    .leading_zeros(leading_zeros),
`endif
    .target_invalid(target_invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_hw();
    for (int i = 0; i < 8; i++) hw[i] = 32'd0;
  endtask

  // Returns with the checker in READY.
  task automatic load_bits(input logic [31:0] b);
    bits = b; bits_load = 1'b1;
    @(negedge clk);
    bits_load = 1'b0;
    @(negedge clk);
  endtask

  // Streams hw[0..7] back to back; returns in the RESULT cycle.
  task automatic send_frame(input string t, input logic [31:0] n);
    int early = 0;
    for (int i = 0; i < 8; i++) begin
      hash_valid = 1'b1; hash_word = hw[i]; hash_last = (i == 7); nonce = n;
      @(negedge clk);
      if (i < 7 && result_valid) early++;
    end
    hash_valid = 1'b0; hash_last = 1'b0;
    chk({t, ".early_rv"}, early, 0);
  endtask

  task automatic check_result(input string t, input logic m, input logic [31:0] n);
    chk({t, ".rv"}, result_valid, 1);
    chk({t, ".ready_low"}, hash_ready, 0);
    chk({t, ".meets"}, meets_target, m);
    chk({t, ".nonce"}, found_nonce, n);
    @(negedge clk);
    chk({t, ".rv_end"}, result_valid, 0);
    chk({t, ".meets_hold"}, meets_target, m);
    chk({t, ".nonce_hold"}, found_nonce, n);
    chk({t, ".ready_back"}, hash_ready, 1);
  endtask

  task automatic all_zero(input string t);
    chk({t, ".ready"}, hash_ready, 0);
    chk({t, ".rv"}, result_valid, 0);
    chk({t, ".meets"}, meets_target, 0);
    chk({t, ".nonce"}, found_nonce, 0);
    chk({t, ".ferr"}, frame_error, 0);
    chk({t, ".tinv"}, target_invalid, 0);
  endtask

  initial begin
    bits = '0; bits_load = 1'b0; hash_valid = 1'b0; hash_word = '0;
    hash_last = 1'b0; nonce = '0;
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle.ready", hash_ready, 0);
    hash_valid = 1'b1; hash_last = 1'b1;
    @(negedge clk);
    chk("idle.ignore", frame_error, 0);
    hash_valid = 1'b0; hash_last = 1'b0;

    // Target 0x00000000_FFFF0000_0..0
    load_bits(32'h1d00ffff);
    chk("1d.tinv", target_invalid, 0);
    chk("1d.ready", hash_ready, 1);
    clr_hw(); hw[1] = 32'h0000FFFF;
    send_frame("a", 32'h1234);
`ifdef HASH_CHECK_LZ_COUNT_EN
    chk("a.lz", leading_zeros, 48);
`endif
    check_result("a", 1'b1, 32'h1234);
    clr_hw(); hw[0] = 32'h1;
    send_frame("b", 32'h55);
`ifdef HASH_CHECK_LZ_COUNT_EN
    chk("b.lz", leading_zeros, 31);
`endif
    check_result("b", 1'b0, 32'h55);
    clr_hw(); hw[1] = 32'hFFFF0000;
    send_frame("eq", 32'h66);
    check_result("eq", 1'b1, 32'h66);
    hw[1] = 32'hFFFF0001;
    send_frame("gt1", 32'h67);
    check_result("gt1", 1'b0, 32'h67);
    hw[1] = 32'hFFFEFFFF; hw[7] = 32'hFFFFFFFF;
    send_frame("lt1", 32'h68);
    check_result("lt1", 1'b1, 32'h68);

    // E=3: target = 0x123456 in word 7
    load_bits(32'h03123456);
    clr_hw(); hw[7] = 32'h00123457;
    send_frame("e3gt", 32'h70);
    check_result("e3gt", 1'b0, 32'h70);
    hw[7] = 32'h00123456;
    send_frame("e3eq", 32'h71);
    check_result("e3eq", 1'b1, 32'h71);

    // E=2: target = 0x1234
    load_bits(32'h02123456);
    clr_hw(); hw[7] = 32'h00001234;
    send_frame("e2eq", 32'h72);
    check_result("e2eq", 1'b1, 32'h72);
    hw[7] = 32'h00001235;
    send_frame("e2gt", 32'h73);
    check_result("e2gt", 1'b0, 32'h73);

    // Invalid targets: sign bit, then E=33
    load_bits(32'h04923456);
    chk("sign.tinv", target_invalid, 1);
    clr_hw();
    send_frame("sign", 32'h80);
`ifdef HASH_CHECK_LZ_COUNT_EN
    chk("sign.lz", leading_zeros, 256);
`endif
    check_result("sign", 1'b0, 32'h80);
    load_bits(32'h21000001);
    chk("e33.tinv", target_invalid, 1);
    send_frame("e33", 32'h81);
    check_result("e33", 1'b0, 32'h81);

    // E=32 is the largest valid exponent: target word0 = 0x00000100
    load_bits(32'h20000001);
    chk("e32.tinv", target_invalid, 0);
    clr_hw(); hw[0] = 32'h00000100;
    send_frame("e32eq", 32'h82);
    check_result("e32eq", 1'b1, 32'h82);

    // Short frame: hash_last at index 3
    load_bits(32'h1d00ffff);
    chk("1d2.tinv", target_invalid, 0);
    clr_hw();
    for (int i = 0; i < 4; i++) begin
      hash_valid = 1'b1; hash_word = 32'd0; hash_last = (i == 3);
      @(negedge clk);
    end
    hash_valid = 1'b0; hash_last = 1'b0;
    chk("ferr.pulse", frame_error, 1);
    chk("ferr.no_rv", result_valid, 0);
    @(negedge clk);
    chk("ferr.end", frame_error, 0);
    chk("ferr.no_rv2", result_valid, 0);
    clr_hw(); hw[1] = 32'h0000FFFF;
    send_frame("after_ferr", 32'h99);
    check_result("after_ferr", 1'b1, 32'h99);

    // bits_load while word 5 is offered aborts the frame
    for (int i = 0; i < 5; i++) begin
      hash_valid = 1'b1; hash_word = 32'hFFFFFFFF; nonce = 32'hDEAD;
      @(negedge clk);
    end
    hash_word = 32'hFFFFFFFF; bits = 32'h1d00ffff; bits_load = 1'b1;
    @(negedge clk);
    bits_load = 1'b0; hash_valid = 1'b0;
    chk("abort.rv", result_valid, 0);
    chk("abort.ready", hash_ready, 0);
    @(negedge clk);
    chk("abort.rv2", result_valid, 0);
    chk("abort.ferr", frame_error, 0);
    chk("abort.ready2", hash_ready, 1);
    chk("abort.nonce_kept", found_nonce, 32'h99);
    clr_hw(); hw[1] = 32'hFFFF0000;
    send_frame("after_abort", 32'hAB);
    check_result("after_abort", 1'b1, 32'hAB);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) begin
      hash_valid = 1'b1; hash_word = 32'd0;
      @(negedge clk);
    end
    #3 rst = 1'b1;
    #1 all_zero("async_rst");
    hash_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.ready", hash_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
